// File: rtl/rr_arb8way16.sv
// Round-robin arbiter: 8 lanes share one WIDTH-bit output register.
// The output register uses valid/ready flow control.

module rr_arb8way16_lane #(
    parameter int IDX = 0
) (
    input  logic       req,
    input  logic [2:0] ptr,
    output logic       hi
);
    // Lane is in the upper (first-searched) half of the rotated priority order.
    assign hi = req && (3'(IDX) >= ptr);
endmodule

module rr_arb8way16 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] data,
    output logic [7:0]         ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               busy
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              ptr;
    logic [7:0]              hi_req;
    logic [7:0][WIDTH-1:0]   lane_data;
    logic [2:0]              w_hi, w_lo, win;
    logic                    load;

    assign lane_data = data;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        rr_arb8way16_lane #(.IDX(i)) u_lane (
            .req (req[i]),
            .ptr (ptr),
            .hi  (hi_req[i])
        );
    end

    // Lowest index at or above ptr wins; otherwise wrap to lowest requester overall.
    always_comb begin
        w_hi = 3'd0;
        w_lo = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hi_req[i]) w_hi = 3'(i);
            if (req[i])    w_lo = 3'(i);
        end
        win = (|hi_req) ? w_hi : w_lo;
    end

    assign load = (|req) && (state == EMPTY || out_ready) && !reset;

    always_comb begin
        ack = 8'd0;
        if (load) ack[win] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (load)
            state_nxt = FULL;
        else if (state == FULL && out_ready)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= 3'd0;
            out_data <= '0;
            out_sel  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data <= lane_data[win];
                out_sel  <= win;
                ptr      <= win + 3'd1;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign busy      = out_valid;
endmodule

// File: tb/tb_rr_arb8way16.sv
// Bench for rr_arb8way16: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbiter.

module tb_rr_arb8way16;
    logic         clk;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] data;
    logic [7:0]   ack;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [2:0]   out_sel;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int          m_ptr;
    bit          m_valid;
    logic [15:0] m_data;
    int          m_sel;
    logic [7:0]  e_ack;
    logic [7:0]  s_ack;

    rr_arb8way16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_winner(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_data  = 16'h0;
        m_sel   = 0;
    endtask

    // Samples ack before the edge, advances the model across one edge,
    // and returns 1 ns after the edge.
    task automatic tick();
        int w;
        bit ld;
        #2;
        w     = ref_winner(req, m_ptr);
        ld    = (w >= 0) && (!m_valid || out_ready);
        e_ack = ld ? (8'd1 << w) : 8'd0;
        s_ack = ack;
        @(posedge clk);
        if (ld) begin
            m_data  = data[w*16 +: 16];
            m_sel   = w;
            m_valid = 1;
            m_ptr   = (w + 1) % 8;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        req       = 8'h00;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
        data      = '1;
        #3;
        checks++;
        if (ack !== 8'h00) begin errors++; $display("FAIL reset_ack got %h want 00", ack); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", out_valid, busy); end
        checks++;
        if (out_data !== 16'h0 || out_sel !== 3'd0) begin errors++; $display("FAIL reset_data got %h/%0d want 0/0", out_data, out_sel); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        out_ready        = 1'b1;
        data             = '0;
        data[3*16 +: 16] = 16'hBEEF;
        req              = 8'b0000_1000;
        tick();
        checks++;
        if (s_ack !== 8'h08) begin errors++; $display("FAIL single_ack got %h want 08", s_ack); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_sel !== 3'd3) begin
            errors++; $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=beef s=3", out_valid, out_data, out_sel);
        end
        req = 8'h00;
        tick();
        checks++;
        if (out_valid !== 1'b0 || s_ack !== 8'h00) begin errors++; $display("FAIL single_drain got v=%b ack=%h want v=0 ack=00", out_valid, s_ack); end
    endtask

    task automatic test_rotation();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) data[i*16 +: 16] = 16'h1000 + 16'(i);
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (s_ack !== (8'd1 << (k % 8)) || s_ack !== e_ack) begin
                errors++; $display("FAIL rot_ack[%0d] got %h want %h", k, s_ack, 8'd1 << (k % 8));
            end
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== 16'h1000 + 16'(k % 8)) begin
                errors++; $display("FAIL rot_out[%0d] got s=%0d d=%h want s=%0d d=%h", k, out_sel, out_data, k % 8, 16'h1000 + 16'(k % 8));
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready        = 1'b1;
        data             = '0;
        data[2*16 +: 16] = 16'hA5A5;
        req              = 8'h04;
        tick();
        out_ready = 1'b0;
        data[2*16 +: 16] = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (s_ack !== 8'h00 || out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_sel !== 3'd2) begin
                errors++; $display("FAIL bp_stall[%0d] got ack=%h v=%b d=%h s=%0d want ack=00 v=1 d=a5a5 s=2", k, s_ack, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (s_ack !== 8'h04 || out_valid !== 1'b1 || out_data !== 16'h1234) begin
            errors++; $display("FAIL bp_resume got ack=%h v=%b d=%h want ack=04 v=1 d=1234", s_ack, out_valid, out_data);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) data[i*16 +: 16] = 16'hC000 + 16'(i);
        req = 8'h40;
        tick();
        req = 8'b1000_0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (out_sel !== ((k % 2 == 0) ? 3'd7 : 3'd1) || out_sel !== 3'(m_sel)) begin
                errors++; $display("FAIL wrap[%0d] got s=%0d want %0d", k, out_sel, (k % 2 == 0) ? 7 : 1);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready        = 1'b1;
        data             = '0;
        data[5*16 +: 16] = 16'h5555;
        data[0*16 +: 16] = 16'h0F0F;
        req              = 8'h20;
        tick();
        out_ready = 1'b0;
        req       = 8'h00;
        tick();
        req       = 8'h21;
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 3'd0 || ack !== 8'h00) begin
            errors++; $display("FAIL mid_reset got v=%b d=%h s=%0d ack=%h want all 0", out_valid, out_data, out_sel, ack);
        end
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (s_ack !== 8'h01 || out_sel !== 3'd0 || out_data !== 16'h0F0F) begin
            errors++; $display("FAIL mid_first got ack=%h s=%0d d=%h want 01/0/0f0f", s_ack, out_sel, out_data);
        end
        tick();
        checks++;
        if (s_ack !== 8'h20 || out_sel !== 3'd5) begin
            errors++; $display("FAIL mid_second got ack=%h s=%0d want 20/5", s_ack, out_sel);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_idle();
        do_reset();
        out_ready = 1'b1;
        req       = 8'h02;
        tick();
        req = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (s_ack !== 8'h00 || out_valid !== 1'b0) begin
                errors++; $display("FAIL idle[%0d] got ack=%h v=%b want 00/0", k, s_ack, out_valid);
            end
        end
        req = 8'hFF;
        tick();
        checks++;
        if (s_ack !== 8'h04 || out_sel !== 3'd2) begin
            errors++; $display("FAIL idle_ptr got ack=%h s=%0d want 04/2", s_ack, out_sel);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req       = 8'($urandom) & 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) data[i*32 +: 32] = $urandom;
            tick();
            checks++;
            if (s_ack !== e_ack) begin errors++; $display("FAIL rnd_ack[%0d] got %h want %h", k, s_ack, e_ack); end
            checks++;
            if (out_valid !== m_valid || busy !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", k, out_valid, m_valid); end
            if (m_valid) begin
                checks++;
                if (out_data !== m_data || out_sel !== 3'(m_sel)) begin
                    errors++; $display("FAIL rnd_out[%0d] got d=%h s=%0d want d=%h s=%0d", k, out_data, out_sel, m_data, m_sel);
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = 8'h00;
        data      = '0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arb8way16.md
Name: rr_arb8way16

Overview:
- Round-robin arbiter that shares one 16-bit output channel among 8 requesters.
- Each cycle it picks one requesting lane, which is in effect the select of an 8-way 16-bit mux.
- It captures the chosen lane's word into a single-entry output register and presents it downstream with valid/ready flow control.
- It sits between the per-source word producers and the single consumer (memory write port / register load path).

Parameters:
- WIDTH, 16, data width per lane and of the output word.
- Lane count is fixed at 8; the select is fixed at 3 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  req[i]=1: lane i has a word on its data slice.
- data  input  8*WIDTH  packed lane data; lane i = data[WIDTH*i+WIDTH-1 : WIDTH*i].
- ack  output  8  one-hot, combinational; ack[i]=1 in the cycle lane i's word is captured at the next edge.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word when out_valid&out_ready at an edge.
- out_data  output  WIDTH  captured word.
- out_sel  output  3  index of the lane that supplied out_data.
- busy  output  1  equals out_valid.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0, state=EMPTY.
  - ack forced to 0 while reset is high.
- State machine: EMPTY (out_valid=0) and FULL (out_valid=1).
- Load condition: load = (|req) & (state==EMPTY | out_ready).
  - Data may be captured while FULL only in the same cycle the current word drains.
- Winner selection:
  - Winner w = first i with req[i]=1, scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Selection is purely combinational from req and ptr.
- ack: ack = load ? onehot(w) : 8'b0. Never more than one bit set.
- On an edge with load=1:
  - out_data <= data slice w; out_sel <= w; out_valid <= 1; ptr <= (w+1) mod 8 (3-bit wrap, 7→0).
- On an edge with load=0:
  - If FULL and out_ready: out_valid <= 0 (go EMPTY).
  - out_data and out_sel are held; ptr is held.
- Backpressure: while FULL and out_ready=0, out_data/out_sel stay stable, ack=0, ptr unchanged.
- Latency and throughput:
  - req asserted in cycle t with state EMPTY → ack in cycle t → out_valid=1 with the word in cycle t+1.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- Requester contract:
  - Hold req and data stable until ack is seen high at a clock edge.
  - After that edge, deassert req or present the next word.
  - Dropping req before ack is allowed; that word is simply not taken.
- Simultaneous drain and load: the consumer takes the old word and the new word replaces it on the same edge; out_valid stays 1.
- Fairness: a lane that has just been granted has lowest priority next time. Any continuously requesting lane is granted within 8 loads.
- No request: ack=0 and ptr unchanged. The output drains normally if FULL.
- Reset mid-operation: any held word is discarded (out_valid=0 immediately) and ptr returns to 0. After reset release, the first grant goes to the lowest-index requester.
- out_data/out_sel are registered outputs only; there is no combinational path from data to out_data.

Test Plan:
- Single requester:
  - Stimulus: reset, then req=8'b0000_1000, lane 3 = 16'hBEEF, out_ready=1.
  - Required: ack=8'h08 in that cycle; next cycle out_valid=1, out_data=BEEF, out_sel=3; after req drops, out_valid=0 one cycle later.
- Full rotation:
  - Stimulus: req=8'hFF held, lane i = 16'h1000+i, out_ready=1.
  - Required: out_sel sequence 0,1,2,…,7,0 on consecutive cycles; out_data=1000..1007,1000; ack walks 01,02,04,…,80,01.
- Backpressure:
  - Stimulus: req=8'h04, lane 2 = 16'hA5A5, out_ready=0 for 5 cycles, then 1.
  - Required: out_valid=1 with out_data=A5A5 stable for all 5 cycles; ack=0 during the stall; the next word is captured on the cycle out_ready=1.
- Wrap and fairness:
  - Stimulus: first grant lane 6, so ptr=7. Then req=8'b1000_0010 (lanes 1 and 7) held.
  - Required: grants 7,1,7,1… alternating.
- Reset mid-operation:
  - Stimulus: FULL with out_sel=5, out_ready=0; pulse reset between clock edges.
  - Required: out_valid, out_data and out_sel go to 0 immediately, ack=0. After release, req=8'h21 grants lane 0 first, then lane 5.
- Idle:
  - Stimulus: req=0 for 10 cycles.
  - Required: ack=0, out_valid=0, ptr unchanged (verify via the next grant order).
